// File: rtl/cpu_pkg.sv
// Shared CPU-core definitions for the rename/retire path.
// Holds register-file and ROB geometry, the ROB entry layout, and the
// rule that decides whether a retiring entry hands a register back to
// the free pool.
package cpu_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_IDX_W = 4;
    localparam int PREG_W    = 6;
    localparam int AREG_W    = 5;

    localparam logic [6:0]        OPC_STORE = 7'b0100011;
    localparam logic [PREG_W-1:0] PREG_ZERO = '0;
    localparam logic [AREG_W-1:0] AREG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              has_dest;
        logic [AREG_W-1:0] areg;
        logic [PREG_W-1:0] preg;
        logic [PREG_W-1:0] old_preg;
    } rob_entry_t;

    // x0 has no real mapping and p0 is permanently reserved, so neither
    // is ever returned to the free pool.
    function automatic logic need_free(input rob_entry_t e);
        return e.has_dest && (e.areg != AREG_ZERO) && (e.old_preg != PREG_ZERO);
    endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit circular pointer.
// Ports:
//   clk, rstn : clock and async active-low reset
//   i_inc     : advance the pointer by one this cycle
//   o_idx     : entry index (low IDX_W bits)
//   o_wrap    : wrap bit, toggles each time the index rolls over
//   o_ptr     : full {wrap, idx} value for occupancy arithmetic
module rob_ptr #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_inc,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_wrap,
    output logic [IDX_W:0]   o_ptr
);

    logic [IDX_W:0] r_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + {{IDX_W{1'b0}}, 1'b1};
        end
    end

    assign o_idx  = r_ptr[IDX_W-1:0];
    assign o_wrap = r_ptr[IDX_W];
    assign o_ptr  = r_ptr;

endmodule

// File: rtl/rob_retire.sv
// In-order reorder buffer and retirement engine.
// Rename allocates at the tail, execute marks entries done out of order,
// and the head retires in order, releasing the displaced physical
// register over a valid/ready handshake and reporting the committed
// mapping to the architectural RAT.
// Ports:
//   clk, rstn                        : clock, async active-low reset
//   alloc_valid/has_dest/areg/preg/old_preg, alloc_ready, alloc_rob_idx
//                                    : allocation from rename
//   cpl_valid, cpl_rob_idx           : completion from execute
//   free_valid, free_preg, free_ready: release to the free pool
//   retire_valid/has_dest/areg/preg  : commit report to the RAT
//   rob_count                        : occupied entries
module rob_retire
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 alloc_valid,
    input  logic                 alloc_has_dest,
    input  logic [AREG_W-1:0]    alloc_areg,
    input  logic [PREG_W-1:0]    alloc_preg,
    input  logic [PREG_W-1:0]    alloc_old_preg,
    output logic                 alloc_ready,
    output logic [ROB_IDX_W-1:0] alloc_rob_idx,
    input  logic                 cpl_valid,
    input  logic [ROB_IDX_W-1:0] cpl_rob_idx,
    output logic                 free_valid,
    output logic [PREG_W-1:0]    free_preg,
    input  logic                 free_ready,
    output logic                 retire_valid,
    output logic                 retire_has_dest,
    output logic [AREG_W-1:0]    retire_areg,
    output logic [PREG_W-1:0]    retire_preg,
    output logic [ROB_IDX_W:0]   rob_count
);

    rob_entry_t r_rob [ROB_DEPTH];

    logic [ROB_IDX_W-1:0] w_head_idx;
    logic [ROB_IDX_W-1:0] w_tail_idx;
    logic                 w_head_wrap;
    logic                 w_tail_wrap;
    logic [ROB_IDX_W:0]   w_head_ptr;
    logic [ROB_IDX_W:0]   w_tail_ptr;
    logic                 w_full;
    logic                 w_alloc_fire;
    logic                 w_cpl_fire;
    logic                 w_retirable;
    logic                 w_need_free;
    logic                 w_retire_fire;
    rob_entry_t           w_head;

    rob_ptr #(.IDX_W(ROB_IDX_W)) u_head_ptr (
        .clk    (clk),
        .rstn   (rstn),
        .i_inc  (w_retire_fire),
        .o_idx  (w_head_idx),
        .o_wrap (w_head_wrap),
        .o_ptr  (w_head_ptr)
    );

    rob_ptr #(.IDX_W(ROB_IDX_W)) u_tail_ptr (
        .clk    (clk),
        .rstn   (rstn),
        .i_inc  (w_alloc_fire),
        .o_idx  (w_tail_idx),
        .o_wrap (w_tail_wrap),
        .o_ptr  (w_tail_ptr)
    );

    assign w_full       = (w_head_idx == w_tail_idx) && (w_head_wrap != w_tail_wrap);
    assign rob_count    = w_tail_ptr - w_head_ptr;
    // Fullness comes from registered pointers only, so a retire in this
    // cycle frees the slot for the next cycle, not this one.
    assign alloc_ready  = !w_full;
    assign alloc_rob_idx = w_tail_idx;
    assign w_alloc_fire = alloc_valid && alloc_ready;

    // A completion racing the allocation of the same slot belongs to a
    // stale instruction and must not mark the new one done.
    assign w_cpl_fire = cpl_valid && r_rob[cpl_rob_idx].valid &&
                        !(w_alloc_fire && (cpl_rob_idx == w_tail_idx));

    assign w_head        = r_rob[w_head_idx];
    assign w_retirable   = w_head.valid && w_head.done;
    assign w_need_free   = need_free(w_head);
    assign w_retire_fire = w_retirable && (!w_need_free || free_ready);

    assign free_valid      = w_retirable && w_need_free;
    assign free_preg       = w_head.old_preg;
    assign retire_valid    = w_retire_fire;
    assign retire_has_dest = w_head.has_dest;
    assign retire_areg     = w_head.areg;
    assign retire_preg     = w_head.preg;

    // Update order matters: a late completion of the retiring head must
    // not leave a stale done bit behind, so the retire clear follows it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_rob[i] <= '0;
            end
        end else begin
            if (w_cpl_fire) begin
                r_rob[cpl_rob_idx].done <= 1'b1;
            end
            if (w_retire_fire) begin
                r_rob[w_head_idx].valid <= 1'b0;
                r_rob[w_head_idx].done  <= 1'b0;
            end
            if (w_alloc_fire) begin
                r_rob[w_tail_idx].valid    <= 1'b1;
                r_rob[w_tail_idx].done     <= 1'b0;
                r_rob[w_tail_idx].has_dest <= alloc_has_dest;
                r_rob[w_tail_idx].areg     <= alloc_areg;
                r_rob[w_tail_idx].preg     <= alloc_preg;
                r_rob[w_tail_idx].old_preg <= alloc_old_preg;
            end
        end
    end

endmodule
